// File: rtl/hci_core_mem_responder_if.sv
// Shared HCI defaults and the HCI-Core handshake bundle used by the responder.

package hci_package;
  parameter int unsigned DEFAULT_DW = 32;
  parameter int unsigned DEFAULT_BW = 8;
  parameter int unsigned DEFAULT_AW = 32;
endpackage

interface hci_core_intf #(
  parameter int unsigned DW = hci_package::DEFAULT_DW,
  parameter int unsigned BW = hci_package::DEFAULT_BW,
  parameter int unsigned AW = hci_package::DEFAULT_AW,
  parameter int unsigned UW = 1
) ();
  logic             req;
  logic             gnt;
  logic [AW-1:0]    add;
  logic             wen;
  logic [DW-1:0]    data;
  logic [DW/BW-1:0] be;
  logic [UW-1:0]    user;
  logic [DW-1:0]    r_data;
  logic [UW-1:0]    r_user;
  logic             r_valid;
  logic             lrdy;

  modport initiator (
    output req, add, wen, data, be, user, lrdy,
    input  gnt, r_data, r_user, r_valid
  );

  modport target (
    input  req, add, wen, data, be, user, lrdy,
    output gnt, r_data, r_user, r_valid
  );
endinterface

// File: rtl/hci_core_mem_responder.sv
// HCI-Core target that bridges onto a 1-cycle-latency SRAM port.
// Every grant yields one in-order response. A one-cycle stage tracks the
// access in flight, and a small fall-through FIFO parks responses the
// initiator is not ready to take. Grants are credit-limited so the FIFO
// can never overflow.

module hci_core_mem_responder #(
  parameter int unsigned DW         = hci_package::DEFAULT_DW,
  parameter int unsigned BW         = hci_package::DEFAULT_BW,
  parameter int unsigned AW         = hci_package::DEFAULT_AW,
  parameter int unsigned UW         = 1,
  parameter int unsigned MEM_AW     = 10,
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clear_i,
  hci_core_intf.target                    tcdm_target,
  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic [MEM_AW-1:0]               mem_addr_o,
  output logic [DW-1:0]                   mem_wdata_o,
  output logic [DW/BW-1:0]                mem_be_o,
  input  logic [DW-1:0]                   mem_rdata_i,
  output logic [$clog2(RESP_DEPTH+1)-1:0] outstanding_o,
  output logic                            empty_o
);

  localparam int unsigned BEW = DW / BW;
  localparam int unsigned OFF = $clog2(BEW);
  localparam int unsigned CW  = $clog2(RESP_DEPTH + 1);
  localparam int unsigned PW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(RESP_DEPTH - 1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
  } resp_t;

  // Request side: credit-limited grant, memory port driven straight through
  logic [AW-1:0] add;
  logic          gnt;
  logic          unused_add;
  logic [CW-1:0] outstanding_q;

  assign add         = tcdm_target.add;
  assign gnt         = tcdm_target.req & (outstanding_q < DEPTH_C) & ~clear_i;
  assign mem_req_o   = tcdm_target.req & gnt;
  assign mem_we_o    = ~tcdm_target.wen;
  assign mem_addr_o  = add[OFF +: MEM_AW];
  assign mem_wdata_o = tcdm_target.data;
  assign mem_be_o    = tcdm_target.be;
  // Byte-offset and above-memory address bits carry no information here.
  assign unused_add  = ^add;

  assign tcdm_target.gnt = gnt;

  // Response stage: remembers kind and user tag of the access in flight
  logic          stage_valid_q;
  logic          stage_is_read_q;
  logic [UW-1:0] stage_user_q;
  resp_t         stage_resp;

  // Register one stage entry per grant; clear and reset drop it
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst_i || clear_i) begin
      stage_valid_q   <= 1'b0;
      stage_is_read_q <= 1'b0;
      stage_user_q    <= '0;
    end else begin
      stage_valid_q <= gnt;
      if (gnt) begin
        stage_is_read_q <= tcdm_target.wen;
        stage_user_q    <= tcdm_target.user;
      end
    end
  end

  // Read data is only valid in the stage cycle; writes answer with zero.
  assign stage_resp.data = (stage_valid_q && stage_is_read_q) ? mem_rdata_i : '0;
  assign stage_resp.user = stage_valid_q ? stage_user_q : '0;

  // Fall-through response FIFO
  resp_t         fifo_mem [RESP_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] fifo_cnt_q;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_push;
  logic          fifo_pop;
  logic          r_valid;
  resp_t         r_resp;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == DEPTH_C);

  // Oldest response wins: FIFO head if anything is parked, else the stage
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    r_valid = 1'b0;
    r_resp  = '0;
    if (!fifo_empty) begin
      r_valid = 1'b1;
      r_resp  = fifo_mem[rd_ptr_q];
    end else if (stage_valid_q) begin
      r_valid = 1'b1;
      r_resp  = stage_resp;
    end
  end

  // A stage response is parked unless it went straight out this cycle.
  assign fifo_pop  = ~fifo_empty & tcdm_target.lrdy;
  assign fifo_push = stage_valid_q & ~(fifo_empty & tcdm_target.lrdy);

  // FIFO payload storage
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; pointers and count gate every read of it.
    if (fifo_push) begin
      fifo_mem[wr_ptr_q] <= stage_resp;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fifo_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Credit counter: +1 per grant, -1 per accepted response
  logic consumed;
  assign consumed = r_valid & tcdm_target.lrdy;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      outstanding_q <= '0;
    end else begin
      case ({gnt, consumed})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign tcdm_target.r_valid = r_valid;
  assign tcdm_target.r_data  = r_resp.data;
  assign tcdm_target.r_user  = r_resp.user;
  assign outstanding_o       = outstanding_q;
  assign empty_o             = (outstanding_q == '0);

  // The credit limit makes a push into a full FIFO unreachable.
  fifo_no_overflow_a: assert property (
    @(posedge clk_i) disable iff (rst_i) !(fifo_push && fifo_full)
  );

endmodule

// File: tb/tb_hci_core_mem_responder.sv
// Self-checking bench for hci_core_mem_responder: directed scenarios plus
// random traffic against a queue-based reference model of the response path.

module tb_hci_core_mem_responder;

  localparam int unsigned DW         = 32;
  localparam int unsigned BW         = 8;
  localparam int unsigned AW         = 32;
  localparam int unsigned UW         = 2;
  localparam int unsigned MEM_AW     = 4;
  localparam int unsigned RESP_DEPTH = 2;
  localparam int unsigned BEW        = DW / BW;
  localparam int unsigned MEM_WORDS  = 1 << MEM_AW;
  localparam int unsigned CW         = $clog2(RESP_DEPTH + 1);

  typedef struct {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
  } exp_t;

  logic clk = 1'b0;
  logic rst, clr;
  logic req, wen, lrdy;
  logic [AW-1:0]  add;
  logic [DW-1:0]  data;
  logic [BEW-1:0] be;
  logic [UW-1:0]  user;

  logic              mem_req, mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [BEW-1:0]    mem_be;
  logic [DW-1:0]     mem_rdata = '0;
  logic [CW-1:0]     outstanding;
  logic              empty;

  logic [DW-1:0] sram    [MEM_WORDS];
  logic [DW-1:0] mdl_mem [MEM_WORDS];
  exp_t          q [$];

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  hci_core_intf #(.DW(DW), .BW(BW), .AW(AW), .UW(UW)) tcdm ();

  assign tcdm.req  = req;
  assign tcdm.wen  = wen;
  assign tcdm.add  = add;
  assign tcdm.data = data;
  assign tcdm.be   = be;
  assign tcdm.user = user;
  assign tcdm.lrdy = lrdy;

  hci_core_mem_responder #(
    .DW(DW), .BW(BW), .AW(AW), .UW(UW),
    .MEM_AW(MEM_AW), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clr),
    .tcdm_target   (tcdm),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_be_o      (mem_be),
    .mem_rdata_i   (mem_rdata),
    .outstanding_o (outstanding),
    .empty_o       (empty)
  );

  // SRAM behind the memory port: one-cycle read latency, byte-masked writes
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int i = 0; i < BEW; i++)
          if (mem_be[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BEW-1:0] b,
                       input logic [UW-1:0] u, input logic ready);
    req = r; wen = w; add = a; data = d; be = b; user = u; lrdy = ready;
  endtask

  task automatic idle(input logic ready);
    drive(1'b0, 1'b1, '0, '0, '0, '0, ready);
  endtask

  // Outputs required while nothing is pending after reset or clear
  task automatic check_idle(input string tag);
    check_eq({tag, "_r_valid"}, tcdm.r_valid, 1'b0);
    check_eq({tag, "_r_data"}, tcdm.r_data, '0);
    check_eq({tag, "_r_user"}, tcdm.r_user, '0);
    check_eq({tag, "_outstanding"}, outstanding, '0);
    check_eq({tag, "_empty"}, empty, 1'b1);
  endtask

  // One clock: check outputs mid-cycle against the model, then advance it
  task automatic tick();
    logic gnt_e, rv_e;
    int unsigned idx;
    exp_t e;
    @(negedge clk);
    idx   = (add >> 2) % MEM_WORDS;
    gnt_e = req && (q.size() < RESP_DEPTH) && !clr;
    rv_e  = (q.size() != 0);
    check_eq("gnt", tcdm.gnt, gnt_e);
    check_eq("mem_req", mem_req, gnt_e);
    if (gnt_e) begin
      check_eq("mem_we", mem_we, !wen);
      check_eq("mem_addr", mem_addr, idx);
      if (!wen) begin
        check_eq("mem_wdata", mem_wdata, data);
        check_eq("mem_be", mem_be, be);
      end
    end
    check_eq("r_valid", tcdm.r_valid, rv_e);
    if (rv_e) begin
      check_eq("r_data", tcdm.r_data, q[0].data);
      check_eq("r_user", tcdm.r_user, q[0].user);
    end
    check_eq("outstanding", outstanding, q.size());
    check_eq("empty", empty, q.size() == 0);

    if (rst || clr) begin
      q.delete();
    end else begin
      if (rv_e && lrdy) void'(q.pop_front());
      if (gnt_e) begin
        e.data = wen ? mdl_mem[idx] : '0;
        e.user = user;
        q.push_back(e);
      end
    end
    if (gnt_e && !wen)
      for (int i = 0; i < BEW; i++)
        if (be[i]) mdl_mem[idx][8*i +: 8] = data[8*i +: 8];
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      mdl_mem[i] = $urandom;
      sram[i]    = mdl_mem[i];
    end
    mdl_mem[0] = 32'hA; sram[0] = 32'hA;
    mdl_mem[1] = 32'hB; sram[1] = 32'hB;
    mdl_mem[2] = 32'hC; sram[2] = 32'hC;

    // Reset state
    rst = 1'b1; clr = 1'b0;
    idle(1'b1);
    @(posedge clk); #1;
    check_idle("reset");
    tick();
    rst = 1'b0;

    // Back-to-back reads of 0x0, 0x4, 0x8 with lrdy high
    drive(1'b1, 1'b1, 32'h0, '0, 4'hF, '0, 1'b1); tick();
    drive(1'b1, 1'b1, 32'h4, '0, 4'hF, '0, 1'b1); tick();
    drive(1'b1, 1'b1, 32'h8, '0, 4'hF, '0, 1'b1); tick();
    idle(1'b1); tick(); tick();

    // Write then read back at 0x10
    drive(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, '0, 1'b1); tick();
    drive(1'b1, 1'b1, 32'h10, '0, 4'hF, '0, 1'b1); tick();
    idle(1'b1); tick(); tick();
    check_eq("wr_rd_mem", sram[4], 32'hDEADBEEF);

    // Credit limit: four held reads with lrdy low, then drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h20, '0, 4'hF, 2'd1, 1'b0); tick();
    end
    check_eq("credit_outstanding", outstanding, RESP_DEPTH);
    check_eq("credit_gnt", tcdm.gnt, 1'b0);
    drive(1'b1, 1'b1, 32'h24, '0, 4'hF, 2'd2, 1'b1); tick(); tick();
    idle(1'b1); tick(); tick(); tick();

    // User tag alignment
    drive(1'b1, 1'b1, 32'h0, '0, 4'hF, 2'd1, 1'b1); tick();
    drive(1'b1, 1'b1, 32'h4, '0, 4'hF, 2'd0, 1'b1); tick();
    idle(1'b1); tick(); tick();

    // Clear with two responses pending
    drive(1'b1, 1'b1, 32'h8, '0, 4'hF, 2'd3, 1'b0); tick(); tick();
    idle(1'b0); tick();
    clr = 1'b1; drive(1'b1, 1'b1, 32'h8, '0, 4'hF, 2'd3, 1'b0); tick();
    clr = 1'b0;
    check_idle("clear");
    idle(1'b1); tick(); tick(); tick();

    // Reset while a grant sits in the stage
    drive(1'b1, 1'b1, 32'hC, '0, 4'hF, 2'd2, 1'b0); tick();
    rst = 1'b1; idle(1'b0); tick();
    check_idle("mid_reset");
    rst = 1'b0;
    idle(1'b1); tick(); tick(); tick();

    // Random traffic with occasional clear and reset
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, $urandom,
            $urandom, 4'($urandom), 2'($urandom), $urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; clr = 1'b0;
    idle(1'b1);
    repeat (4) tick();
    check_idle("drained");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
